// File: rtl/pwm_duty_ramper.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_duty_ramper
//  Description : Sequences the duty input of a PWM generator. A target duty is
//                accepted over a valid/ready handshake. The live duty then
//                ramps toward the target by STEP per update interval. The duty
//                output changes only at PWM period boundaries, so the PWM
//                output never glitches.
//  Ports       : clk, rst          - clock, asynchronous active-high reset
//                tgt_valid/ready   - target handshake (ready only in IDLE)
//                tgt_duty          - requested final duty
//                ramp_rate         - extra periods between steps (0 = every period)
//                abort             - stop the ramp and hold the current duty
//                duty              - registered live duty to the PWM block
//                period_start      - high in the cycle in which the period counter is 0
//                busy              - ramp in progress
//                done              - one-cycle pulse when the target is reached
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_duty_ramper #(
   parameter int DUTY_W       = 8,
   parameter int STEP         = 1,
   parameter int DEFAULT_DUTY = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tgt_valid,
   output logic              tgt_ready,
   input  logic [DUTY_W-1:0] tgt_duty,
   input  logic [7:0]        ramp_rate,
   input  logic              abort,
   output logic [DUTY_W-1:0] duty,
   output logic              period_start,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RAMP_UP   = 2'd1,
      RAMP_DOWN = 2'd2
   } state_t;

   localparam logic [DUTY_W:0]   c_STEP_EXT   = (DUTY_W+1)'(STEP);
   localparam logic [DUTY_W-1:0] c_RESET_DUTY = DUTY_W'(DEFAULT_DUTY);

   state_t            state_q, state_d;
   logic [DUTY_W-1:0] duty_q,  duty_d;
   logic [DUTY_W-1:0] pcnt_q,  pcnt_d;
   logic [DUTY_W-1:0] tgt_q,   tgt_d;
   logic [7:0]        rcnt_q,  rcnt_d;
   logic [7:0]        rate_q,  rate_d;
   logic              done_q,  done_d;

   logic              w_boundary;
   logic [DUTY_W:0]   w_diff_up;
   logic [DUTY_W:0]   w_diff_dn;
   logic [DUTY_W:0]   w_step_up;
   logic [DUTY_W:0]   w_step_dn;
   logic [DUTY_W-1:0] w_duty_up;
   logic [DUTY_W-1:0] w_duty_dn;

   // The edge on which pcnt wraps to zero is the only edge allowed to move duty.
   assign w_boundary = (pcnt_q == {DUTY_W{1'b1}});

   // Distances are formed one bit wider so the unused direction's wrap never
   // reaches the selected step; the chosen step is clamped to the remaining
   // distance so duty lands exactly on the target and never wraps.
   assign w_diff_up = {1'b0, tgt_q}  - {1'b0, duty_q};
   assign w_diff_dn = {1'b0, duty_q} - {1'b0, tgt_q};
   assign w_step_up = (w_diff_up < c_STEP_EXT) ? w_diff_up : c_STEP_EXT;
   assign w_step_dn = (w_diff_dn < c_STEP_EXT) ? w_diff_dn : c_STEP_EXT;
   assign w_duty_up = duty_q + w_step_up[DUTY_W-1:0];
   assign w_duty_dn = duty_q - w_step_dn[DUTY_W-1:0];

   always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
      pcnt_d  = pcnt_q + 1'b1;
      tgt_d   = tgt_q;
      rcnt_d  = rcnt_q;
      rate_d  = rate_q;
      done_d  = 1'b0;

      if (abort) begin
         // Abort beats both a coincident accept and a coincident step.
         state_d = IDLE;
         rcnt_d  = 8'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (tgt_valid) begin
                  tgt_d  = tgt_duty;
                  rate_d = ramp_rate;
                  rcnt_d = ramp_rate;
                  if (tgt_duty == duty_q) begin
                     done_d = 1'b1;
                  end else if (tgt_duty > duty_q) begin
                     state_d = RAMP_UP;
                  end else begin
                     state_d = RAMP_DOWN;
                  end
               end
            end
            RAMP_UP, RAMP_DOWN: begin
               if (w_boundary) begin
                  if (rcnt_q != 8'd0) begin
                     rcnt_d = rcnt_q - 8'd1;
                  end else begin
                     rcnt_d = rate_q;
                     duty_d = (state_q == RAMP_UP) ? w_duty_up : w_duty_dn;
                     if (duty_d == tgt_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                     end
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         duty_q  <= c_RESET_DUTY;
         pcnt_q  <= '0;
         tgt_q   <= '0;
         rcnt_q  <= 8'd0;
         rate_q  <= 8'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         duty_q  <= duty_d;
         pcnt_q  <= pcnt_d;
         tgt_q   <= tgt_d;
         rcnt_q  <= rcnt_d;
         rate_q  <= rate_d;
         done_q  <= done_d;
      end
   end

   assign duty         = duty_q;
   assign period_start = (pcnt_q == '0);
   assign tgt_ready    = (state_q == IDLE);
   assign busy         = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);
   assign done         = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_ramper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_duty_ramper
//  Description : Directed bench for pwm_duty_ramper. One instance uses the
//                default STEP of 1, a second uses STEP=4 for the clamp case.
//                Inputs are driven and outputs sampled on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_duty_ramper;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tgt_valid = 1'b0;
   logic [7:0] tgt_duty  = 8'd0;
   logic [7:0] ramp_rate = 8'd0;
   logic       abort     = 1'b0;
   logic       tgt_ready, period_start, busy, done;
   logic [7:0] duty;

   logic       tv2 = 1'b0;
   logic [7:0] td2 = 8'd0;
   logic [7:0] rr2 = 8'd0;
   logic       ab2 = 1'b0;
   logic       rdy2, ps2, busy2, done2;
   logic [7:0] duty2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pwm_duty_ramper #(.DUTY_W(8), .STEP(1), .DEFAULT_DUTY(0)) dut (
      .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
      .tgt_duty(tgt_duty), .ramp_rate(ramp_rate), .abort(abort), .duty(duty),
      .period_start(period_start), .busy(busy), .done(done)
   );

   pwm_duty_ramper #(.DUTY_W(8), .STEP(4), .DEFAULT_DUTY(0)) dut_s4 (
      .clk(clk), .rst(rst), .tgt_valid(tv2), .tgt_ready(rdy2),
      .tgt_duty(td2), .ramp_rate(rr2), .abort(ab2), .duty(duty2),
      .period_start(ps2), .busy(busy2), .done(done2)
   );

   task automatic test_reset();
      int n;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (duty !== 8'd0)      begin errors++; $display("FAIL reset_duty got=%0d exp=0", duty); end
      checks++; if (tgt_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", tgt_ready); end
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL reset_pstart got=%b exp=1", period_start); end
      checks++; if (duty2 !== 8'd0)     begin errors++; $display("FAIL reset_duty_s4 got=%0d exp=0", duty2); end
      n = 0;
      repeat (255) begin
         @(negedge clk);
         if (period_start) n++;
      end
      checks++; if (n != 0) begin errors++; $display("FAIL pstart_gap got=%0d pulses exp=0", n); end
      @(negedge clk);
      checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL pstart_256 got=%b exp=1", period_start); end
   endtask

   // 0 -> 51 at rate 0: one step per boundary, 51 boundaries, done together
   // with the first period showing 51.
   task automatic test_ramp_up();
      int k, nb, exp_d;
      bit fin, glitch, early_done, bad_busy;
      logic [7:0] prev;
      @(negedge clk);
      tgt_valid = 1'b1; tgt_duty = 8'd51; ramp_rate = 8'd0;
      @(negedge clk);
      tgt_valid = 1'b0;
      k = 1; nb = 0; exp_d = 0; fin = 0; glitch = 0; early_done = 0; bad_busy = 0;
      prev = duty;
      while (!fin && k < 20000) begin
         if (k >= 2 && period_start) begin
            nb++;
            exp_d++;
            checks++; if (duty !== 8'(exp_d)) begin errors++; $display("FAIL up_duty got=%0d exp=%0d", duty, exp_d); end
            if (exp_d == 51) begin
               fin = 1;
               checks++; if (done !== 1'b1) begin errors++; $display("FAIL up_done got=%b exp=1", done); end
               checks++; if (busy !== 1'b0) begin errors++; $display("FAIL up_busy_end got=%b exp=0", busy); end
               checks++; if (nb != 51)      begin errors++; $display("FAIL up_periods got=%0d exp=51", nb); end
            end else if (done) early_done = 1;
         end else begin
            if (duty !== prev) glitch = 1;
            if (done) early_done = 1;
            if (busy !== 1'b1) bad_busy = 1;
         end
         prev = duty;
         if (!fin) begin @(negedge clk); k++; end
      end
      checks++; if (!fin)       begin errors++; $display("FAIL up_timeout got=%0d exp_duty=51", duty); end
      checks++; if (glitch)     begin errors++; $display("FAIL up_midperiod_change got=1 exp=0"); end
      checks++; if (early_done) begin errors++; $display("FAIL up_early_done got=1 exp=0"); end
      checks++; if (bad_busy)   begin errors++; $display("FAIL up_busy got=0 exp=1"); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL up_done_pulse got=%b exp=0", done); end
   endtask

   // 51 -> 10 at rate 3: steps on boundaries 4,8,..,164; a target offered
   // mid-ramp must be ignored.
   task automatic test_ramp_down();
      int k, nb, exp_d, exp_rc;
      bit fin, glitch, early_done;
      logic [7:0] prev;
      @(negedge clk);
      tgt_valid = 1'b1; tgt_duty = 8'd10; ramp_rate = 8'd3;
      @(negedge clk);
      tgt_valid = 1'b0;
      k = 1; nb = 0; exp_d = 51; exp_rc = 3; fin = 0; glitch = 0; early_done = 0;
      prev = duty;
      while (!fin && k < 50000) begin
         tgt_valid = 1'b0;
         if (k >= 2 && period_start) begin
            nb++;
            if (exp_rc != 0) exp_rc--;
            else begin exp_rc = 3; exp_d--; end
            checks++; if (duty !== 8'(exp_d)) begin errors++; $display("FAIL dn_duty got=%0d exp=%0d at period %0d", duty, exp_d, nb); end
            if (exp_d == 10) begin
               fin = 1;
               checks++; if (done !== 1'b1) begin errors++; $display("FAIL dn_done got=%b exp=1", done); end
               checks++; if (nb != 164)     begin errors++; $display("FAIL dn_periods got=%0d exp=164", nb); end
            end else if (done) early_done = 1;
         end else begin
            if (duty !== prev) glitch = 1;
            if (done) early_done = 1;
         end
         if (k == 1000) begin
            checks++; if (tgt_ready !== 1'b0) begin errors++; $display("FAIL dn_ready got=%b exp=0", tgt_ready); end
            tgt_valid = 1'b1; tgt_duty = 8'd200; ramp_rate = 8'd0;
         end
         prev = duty;
         if (!fin) begin @(negedge clk); k++; end
      end
      tgt_valid = 1'b0;
      checks++; if (!fin)       begin errors++; $display("FAIL dn_timeout got=%0d exp_duty=10", duty); end
      checks++; if (glitch)     begin errors++; $display("FAIL dn_midperiod_change got=1 exp=0"); end
      checks++; if (early_done) begin errors++; $display("FAIL dn_early_done got=1 exp=0"); end
   endtask

   task automatic test_equal_target();
      bit bad;
      @(negedge clk);
      tgt_valid = 1'b1; tgt_duty = 8'd10; ramp_rate = 8'd5;
      @(negedge clk);
      tgt_valid = 1'b0;
      checks++; if (done !== 1'b1)      begin errors++; $display("FAIL eq_done got=%b exp=1", done); end
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL eq_busy got=%b exp=0", busy); end
      checks++; if (tgt_ready !== 1'b1) begin errors++; $display("FAIL eq_ready got=%b exp=1", tgt_ready); end
      @(negedge clk);
      checks++; if (done !== 1'b0)      begin errors++; $display("FAIL eq_done_pulse got=%b exp=0", done); end
      bad = 0;
      repeat (600) begin
         @(negedge clk);
         if (busy !== 1'b0 || duty !== 8'd10 || done !== 1'b0) bad = 1;
      end
      checks++; if (bad) begin errors++; $display("FAIL eq_hold got=%0d exp=10 idle", duty); end
   endtask

   // STEP=4, 0 -> 10: expected 4, 8, then clamped to 10, never 12.
   task automatic test_clamp();
      int k, nb, exp_d;
      bit fin, over;
      @(negedge clk);
      tv2 = 1'b1; td2 = 8'd10; rr2 = 8'd0;
      @(negedge clk);
      tv2 = 1'b0;
      k = 1; nb = 0; fin = 0; over = 0;
      while (!fin && k < 2000) begin
         if (duty2 > 8'd10) over = 1;
         if (k >= 2 && ps2) begin
            nb++;
            exp_d = (nb * 4 > 10) ? 10 : nb * 4;
            checks++; if (duty2 !== 8'(exp_d)) begin errors++; $display("FAIL clamp_duty got=%0d exp=%0d", duty2, exp_d); end
            if (nb == 3) begin
               fin = 1;
               checks++; if (done2 !== 1'b1) begin errors++; $display("FAIL clamp_done got=%b exp=1", done2); end
            end
         end
         if (!fin) begin @(negedge clk); k++; end
      end
      checks++; if (!fin) begin errors++; $display("FAIL clamp_timeout got=%0d exp=10", duty2); end
      repeat (600) begin
         @(negedge clk);
         if (duty2 !== 8'd10) over = 1;
      end
      checks++; if (over) begin errors++; $display("FAIL clamp_overshoot got=%0d exp=10", duty2); end
   endtask

   task automatic test_abort_reset();
      int k;
      bit bad;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      tgt_valid = 1'b1; tgt_duty = 8'd200; ramp_rate = 8'd0;
      @(negedge clk);
      tgt_valid = 1'b0;
      k = 0;
      while (!(period_start && duty == 8'd37) && k < 20000) begin
         @(negedge clk); k++;
      end
      checks++; if (k >= 20000) begin errors++; $display("FAIL abort_reach37 got=%0d exp=37", duty); end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++; if (tgt_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b exp=1", tgt_ready); end
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
      checks++; if (duty !== 8'd37)     begin errors++; $display("FAIL abort_duty got=%0d exp=37", duty); end
      bad = 0;
      repeat (600) begin
         @(negedge clk);
         if (duty !== 8'd37 || done !== 1'b0 || busy !== 1'b0) bad = 1;
      end
      checks++; if (bad) begin errors++; $display("FAIL abort_hold got=%0d exp=37 no done", duty); end

      // Abort together with an accept: the target is discarded.
      abort = 1'b1; tgt_valid = 1'b1; tgt_duty = 8'd90;
      @(negedge clk);
      abort = 1'b0; tgt_valid = 1'b0;
      bad = 0;
      repeat (600) begin
         if (duty !== 8'd37 || done !== 1'b0 || busy !== 1'b0) bad = 1;
         @(negedge clk);
      end
      checks++; if (bad) begin errors++; $display("FAIL abort_vs_accept got=%0d exp=37 idle", duty); end

      // New ramp, then reset in the middle of a period.
      tgt_valid = 1'b1; tgt_duty = 8'd100; ramp_rate = 8'd0;
      @(negedge clk);
      tgt_valid = 1'b0;
      repeat (300) @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ramp2_busy got=%b exp=1", busy); end
      #2 rst = 1'b1;
      #1;
      checks++; if (duty !== 8'd0)      begin errors++; $display("FAIL rst_async_duty got=%0d exp=0", duty); end
      checks++; if (tgt_ready !== 1'b1) begin errors++; $display("FAIL rst_async_ready got=%b exp=1", tgt_ready); end
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_async_busy got=%b exp=0", busy); end
      checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL rst_async_pstart got=%b exp=1", period_start); end
      @(negedge clk);
      rst = 1'b0;
      repeat (300) @(negedge clk);
      checks++; if (duty !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL rst_ramp_lost got=%0d busy=%b exp=0 busy=0", duty, busy); end
   endtask

   initial begin
      test_reset();
      test_ramp_up();
      test_ramp_down();
      test_equal_target();
      test_clamp();
      test_abort_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
